vme_master_seq: RTL and testbench

- Sequences single VME master cycles (A32/A24/A16, D16/D32) on the board VME buffer pins, from a one-deep request interface driven by the system-side VME slave.
- Owns the AS#/DS#/DTACK# timing, the data bus direction, the bus-error timeout and the DEADDEAD read substitution.
- Sits between the interconnect and the vme_* pads in the top level, in the clk50 domain.

---
 rtl/vme_master_seq_if.sv | 26 ++
 rtl/vme_master_seq.sv | 244 ++++++++++++++++++++++++
 tb/tb_vme_master_seq.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vme_master_seq_if.sv
// Request/response channel between the system-side VME slave and the
// VME master cycle sequencer. One request in flight at a time.
interface vme_master_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [30:0] req_addr;
    logic [5:0]  req_am;
    logic        req_lword;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_berr;

    // Requester side (system-side VME slave)
    modport master (
        output req_valid, req_write, req_addr, req_am, req_lword, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_berr
    );

    // Sequencer side
    modport slave (
        input  req_valid, req_write, req_addr, req_am, req_lword, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_berr
    );
endinterface

// File: rtl/vme_master_seq.sv
// Single-cycle VME master sequencer: drives address/AM/WRITE#, then AS#,
// then DS0#/DS1#, waits for a synchronized DTACK# or times out with a bus
// error, releases the strobes and reports one response pulse. A new cycle
// cannot begin while a slave is still holding DTACK# asserted.
module vme_master_seq #(
    parameter int ADDR_SETUP_CYC = 2,
    parameter int DS_DELAY_CYC   = 1,
    parameter int TIMEOUT_CYC    = 500,
    parameter int TO_W           = 10
) (
    input  logic             clk50,
    input  logic             sys_rst_n,
    vme_master_seq_if.slave  req_if,
    output logic [30:0]      vme_a_o,
    output logic [5:0]       vme_am_o,
    output logic             vme_lword_n,
    output logic             vme_write_n,
    output logic             vme_as_n,
    output logic             vme_ds0_n,
    output logic             vme_ds1_n,
    output logic [31:0]      vme_db_o,
    output logic             vme_db_oe,
    input  logic [31:0]      vme_db_i,
    input  logic             vme_dtack_n
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_AS    = 3'd2,
        ST_WAIT  = 3'd3,
        ST_REL   = 3'd4,
        ST_RSP   = 3'd5,
        ST_DREL  = 3'd6
    } state_t;

    localparam logic [TO_W-1:0] CNT_ZERO   = {TO_W{1'b0}};
    localparam logic [TO_W-1:0] CNT_ONE    = TO_W'(1);
    localparam logic [TO_W-1:0] SETUP_LAST = TO_W'(ADDR_SETUP_CYC - 1);
    localparam logic [TO_W-1:0] DS_LAST    = TO_W'(DS_DELAY_CYC - 1);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [31:0]     BERR_DATA  = 32'hDEAD_DEAD;

    state_t          state_r, state_s;
    logic [TO_W-1:0] cnt_r, cnt_s;
    logic            dtk_meta_r, dtk_r;
    logic            berr_r, berr_s;
    logic            ready_s, accept_s;
    logic            rsp_valid_r, rsp_berr_r;
    logic [31:0]     rsp_rdata_r;

    logic [30:0]     a_s;
    logic [5:0]      am_s;
    logic            lword_n_s, write_n_s, as_s, ds_s, oe_s;
    logic [31:0]     db_s, rdata_s;
    logic            valid_s, rsp_berr_s;

    assign req_if.req_ready = ready_s;
    assign req_if.rsp_valid = rsp_valid_r;
    assign req_if.rsp_rdata = rsp_rdata_r;
    assign req_if.rsp_berr  = rsp_berr_r;

    // Two-flop synchronizer turning asynchronous DTACK# into active-high dtk
    always_ff @(posedge clk50 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dtk_meta_r <= 1'b0;
            dtk_r      <= 1'b0;
        end else begin
            dtk_meta_r <= ~vme_dtack_n;
            dtk_r      <= dtk_meta_r;
        end
    end

    // Accept only in IDLE, out of reset, and with no slave still holding DTACK
    always_comb begin
        if (sys_rst_n && (state_r == ST_IDLE) && !dtk_r) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
        accept_s = ready_s & req_if.req_valid;
    end

    // State register
    always_ff @(posedge clk50 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; DTACK is tested before the timeout so it wins a tie
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  if (accept_s) state_s = ST_SETUP; else state_s = ST_IDLE;
            ST_SETUP: if (cnt_r == SETUP_LAST) state_s = ST_AS; else state_s = ST_SETUP;
            ST_AS:    if (cnt_r == DS_LAST) state_s = ST_WAIT; else state_s = ST_AS;
            ST_WAIT: begin
                if (dtk_r) begin
                    state_s = ST_REL;
                end else if (cnt_r == TO_LAST) begin
                    state_s = ST_REL;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_REL:   state_s = ST_RSP;
            ST_RSP:   state_s = ST_DREL;
            ST_DREL: begin
                if (!dtk_r || (cnt_r == TO_LAST)) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DREL;
                end
            end
            default:  state_s = ST_IDLE;
        endcase
    end

    // Next values of the pin, counter and response registers
    always_comb begin
        cnt_s      = cnt_r + CNT_ONE;
        berr_s     = berr_r;
        a_s        = vme_a_o;
        am_s       = vme_am_o;
        lword_n_s  = vme_lword_n;
        write_n_s  = vme_write_n;
        db_s       = vme_db_o;
        oe_s       = vme_db_oe;
        as_s       = vme_as_n;
        ds_s       = vme_ds0_n;
        rdata_s    = rsp_rdata_r;
        valid_s    = 1'b0;
        rsp_berr_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_s = CNT_ZERO;
                if (accept_s) begin
                    a_s       = req_if.req_addr;
                    am_s      = req_if.req_am;
                    lword_n_s = ~req_if.req_lword;
                    write_n_s = ~req_if.req_write;
                    db_s      = req_if.req_wdata;
                    oe_s      = req_if.req_write;
                end else begin
                    oe_s = 1'b0;
                end
            end
            ST_SETUP: begin
                if (cnt_r == SETUP_LAST) begin
                    as_s  = 1'b0;
                    cnt_s = CNT_ZERO;
                end else begin
                    as_s = 1'b1;
                end
            end
            ST_AS: begin
                if (cnt_r == DS_LAST) begin
                    ds_s  = 1'b0;
                    cnt_s = CNT_ZERO;
                end else begin
                    ds_s = 1'b1;
                end
            end
            ST_WAIT: begin
                if (dtk_r) begin
                    ds_s = 1'b1;
                    oe_s = 1'b0;
                    if (vme_write_n) begin
                        rdata_s = vme_lword_n ? {16'h0000, vme_db_i[15:0]} : vme_db_i;
                    end else begin
                        rdata_s = rsp_rdata_r;
                    end
                end else if (cnt_r == TO_LAST) begin
                    ds_s    = 1'b1;
                    oe_s    = 1'b0;
                    berr_s  = 1'b1;
                    rdata_s = BERR_DATA;
                end else begin
                    ds_s = 1'b0;
                end
            end
            ST_REL: begin
                as_s       = 1'b1;
                valid_s    = 1'b1;
                rsp_berr_s = berr_r;
            end
            ST_RSP: begin
                berr_s = 1'b0;
                cnt_s  = CNT_ZERO;
            end
            ST_DREL: begin
                if (cnt_r == TO_LAST) begin
                    cnt_s = cnt_r;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                as_s = 1'b1;
                ds_s = 1'b1;
                oe_s = 1'b0;
            end
        endcase
    end

    // Pin, counter and response registers; reset negates every strobe at once
    always_ff @(posedge clk50 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_r       <= CNT_ZERO;
            berr_r      <= 1'b0;
            vme_a_o     <= 31'h0;
            vme_am_o    <= 6'h0;
            vme_lword_n <= 1'b1;
            vme_write_n <= 1'b1;
            vme_as_n    <= 1'b1;
            vme_ds0_n   <= 1'b1;
            vme_ds1_n   <= 1'b1;
            vme_db_o    <= 32'h0;
            vme_db_oe   <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_berr_r  <= 1'b0;
            rsp_rdata_r <= 32'h0;
        end else begin
            cnt_r       <= cnt_s;
            berr_r      <= berr_s;
            vme_a_o     <= a_s;
            vme_am_o    <= am_s;
            vme_lword_n <= lword_n_s;
            vme_write_n <= write_n_s;
            vme_as_n    <= as_s;
            vme_ds0_n   <= ds_s;
            vme_ds1_n   <= ds_s;
            vme_db_o    <= db_s;
            vme_db_oe   <= oe_s;
            rsp_valid_r <= valid_s;
            rsp_berr_r  <= rsp_berr_s;
            rsp_rdata_r <= rdata_s;
        end
    end

endmodule

// File: tb/tb_vme_master_seq.sv
// Bench for vme_master_seq: a behavioural VME slave answers DS# after a
// chosen number of cycles (or never) and holds DTACK# a chosen time after
// DS# release; each cycle is compared against timing and data computed
// from the bus rules with plain arithmetic.
module tb_vme_master_seq;

    localparam int ADDR_SETUP_CYC = 2;
    localparam int DS_DELAY_CYC   = 1;
    localparam int TIMEOUT_CYC    = 500;

    logic        clk50 = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic [30:0] vme_a_o;
    logic [5:0]  vme_am_o;
    logic        vme_lword_n, vme_write_n, vme_as_n, vme_ds0_n, vme_ds1_n, vme_db_oe;
    logic [31:0] vme_db_o;
    logic [31:0] vme_db_i = 32'h0;
    logic        vme_dtack_n = 1'b1;

    vme_master_seq_if bus ();

    vme_master_seq dut (
        .clk50       (clk50),
        .sys_rst_n   (sys_rst_n),
        .req_if      (bus),
        .vme_a_o     (vme_a_o),
        .vme_am_o    (vme_am_o),
        .vme_lword_n (vme_lword_n),
        .vme_write_n (vme_write_n),
        .vme_as_n    (vme_as_n),
        .vme_ds0_n   (vme_ds0_n),
        .vme_ds1_n   (vme_ds1_n),
        .vme_db_o    (vme_db_o),
        .vme_db_oe   (vme_db_oe),
        .vme_db_i    (vme_db_i),
        .vme_dtack_n (vme_dtack_n)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Slave configuration for the next cycle (0 = never acknowledge)
    int          ack_d = 0;
    int          hold_h = 1;
    logic [31:0] slave_data = 32'h0;
    int          cur_d = 0, cur_h = 1, lo_cnt = 0, hi_cnt = 0;
    logic [31:0] cur_data = 32'h0;

    // Response gap bookkeeping across back-to-back cycles
    int prev_r = 0, prev_gap = 0;
    bit have_prev = 1'b0;

    // 50 MHz clock
    always #10 clk50 = ~clk50;

    // Cycle counter used to timestamp observed events
    always @(posedge clk50) cyc <= cyc + 1;

    // Behavioural VME slave driving DTACK# and read data
    always @(negedge clk50) begin
        if (!vme_ds0_n) begin
            hi_cnt = 0;
            lo_cnt = lo_cnt + 1;
            if (lo_cnt == 1) begin
                cur_d    = ack_d;
                cur_h    = hold_h;
                cur_data = slave_data;
            end
            if (cur_d != 0 && lo_cnt == cur_d) begin
                vme_db_i    = cur_data;
                vme_dtack_n = 1'b0;
            end
        end else begin
            lo_cnt = 0;
            if (!vme_dtack_n) begin
                hi_cnt = hi_cnt + 1;
                if (hi_cnt >= cur_h) vme_dtack_n = 1'b1;
            end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Run one master cycle and check it against the expected bus behaviour
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [5:0] am,
                           input logic lw, input logic [31:0] wdata, input int d,
                           input int h, input logic [31:0] sdata);
        bit          exp_berr, found, got_rsp;
        logic [31:0] exp_rdata;
        int          a_cyc, t_as, t_ds, ds_lo, phase, r_cyc, exp_lat;
        logic        last_oe;

        ack_d      = d;
        hold_h     = h;
        slave_data = sdata;
        exp_berr   = (d == 0) || (d > TIMEOUT_CYC - 2);
        exp_rdata  = exp_berr ? 32'hDEAD_DEAD : (lw ? sdata : {16'h0000, sdata[15:0]});
        exp_lat    = exp_berr ? (ADDR_SETUP_CYC + DS_DELAY_CYC + TIMEOUT_CYC + 1)
                              : (ADDR_SETUP_CYC + DS_DELAY_CYC + d + 2 + 1);

        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr[31:1];
        bus.req_am    = am;
        bus.req_lword = lw;
        bus.req_wdata = wdata;

        found = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            if (bus.req_ready) begin
                found = 1'b1;
                break;
            end
            @(negedge clk50);
        end
        if (!found) begin
            check_val("ready_timeout", 64'd0, 64'd1);
            bus.req_valid = 1'b0;
            return;
        end
        if (have_prev) check_val("ready_gap", cyc - prev_r, prev_gap);
        a_cyc = cyc + 1;

        @(negedge clk50);
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom);
        bus.req_addr  = 31'($urandom);
        bus.req_am    = 6'($urandom);
        bus.req_lword = 1'($urandom);
        bus.req_wdata = $urandom;

        t_as = -1; t_ds = -1; ds_lo = 0; phase = 0; r_cyc = 0;
        last_oe = 1'b0; got_rsp = 1'b0;
        for (int i = 0; i < 700; i++) begin
            if (i > 0) @(negedge clk50);
            if (i == 0) begin
                check_val("addr_valid", {vme_a_o, vme_am_o, vme_as_n}, {addr[31:1], am, 1'b1});
            end
            if (t_as < 0 && !vme_as_n) t_as = cyc;
            if (phase == 0 && !vme_ds0_n) begin
                phase = 1;
                t_ds  = cyc;
                ds_lo = 1;
                last_oe = vme_db_oe;
                check_val("pins", {vme_a_o, vme_am_o, vme_lword_n, vme_write_n, vme_ds1_n},
                          {addr[31:1], am, ~lw, ~wr, 1'b0});
                check_val("db_drive", {vme_db_oe, (wr ? vme_db_o : 32'h0)},
                          {wr, (wr ? wdata : 32'h0)});
            end else if (phase == 1) begin
                if (!vme_ds0_n) begin
                    ds_lo++;
                    last_oe = vme_db_oe;
                end else begin
                    phase = 2;
                    check_val("ds_release", {vme_db_oe, vme_as_n, vme_ds1_n, vme_a_o},
                              {1'b0, 1'b0, 1'b1, addr[31:1]});
                end
            end else if (phase == 2) begin
                check_val("as_release", vme_as_n, 1'b1);
                phase = 3;
            end
            if (bus.rsp_valid) begin
                got_rsp = 1'b1;
                r_cyc   = cyc;
                break;
            end
        end
        if (!got_rsp) begin
            check_val("rsp_timeout", 64'd0, 64'd1);
            return;
        end
        check_val("as_setup", t_as - a_cyc, ADDR_SETUP_CYC);
        check_val("ds_delay", t_ds - t_as, DS_DELAY_CYC);
        check_val("ds_low_len", ds_lo, exp_berr ? TIMEOUT_CYC : d + 2);
        check_val("oe_through_ds", last_oe, wr);
        check_val("latency", r_cyc - a_cyc, exp_lat);
        check_val("rsp_berr", bus.rsp_berr, exp_berr);
        if (!wr || exp_berr) check_val("rsp_rdata", bus.rsp_rdata, exp_rdata);

        prev_r    = r_cyc;
        prev_gap  = exp_berr ? 2 : 1 + ((h > 1) ? h : 1);
        have_prev = 1'b1;
        @(negedge clk50);
        check_val("rsp_pulse", bus.rsp_valid, 1'b0);
    endtask

    // Watchdog so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Main stimulus sequence
    initial begin
        bit found;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 31'h0;
        bus.req_am    = 6'h0;
        bus.req_lword = 1'b0;
        bus.req_wdata = 32'h0;

        #2 sys_rst_n = 1'b0;
        repeat (3) @(negedge clk50);
        check_val("rst_strobes", {vme_as_n, vme_ds0_n, vme_ds1_n, vme_write_n, vme_lword_n}, 5'b11111);
        check_val("rst_ctrl", {vme_db_oe, bus.req_ready, bus.rsp_valid, bus.rsp_berr}, 4'b0000);
        check_val("rst_data", {vme_a_o, vme_am_o, vme_db_o, bus.rsp_rdata}, 101'h0);
        sys_rst_n = 1'b1;
        @(negedge clk50);

        // A32 D32 read, slave answers 100 ns after DS#
        run_txn(1'b0, 32'h1000_0004, 6'h09, 1'b1, 32'h0, 5, 1, 32'h1234_5678);
        // D16 write, slave answers after 3 cycles
        run_txn(1'b1, 32'h0000_2000, 6'h3D, 1'b0, 32'h0000_BEEF, 3, 2, 32'h0);
        // Absent slave: bus error
        run_txn(1'b0, 32'h0ABC_0010, 6'h09, 1'b1, 32'h0, 0, 1, 32'h0);
        // Slave holds DTACK# 20 cycles after release, next request waits
        run_txn(1'b0, 32'h0000_4000, 6'h29, 1'b0, 32'h0, 2, 20, 32'hCAFE_F00D);
        run_txn(1'b1, 32'h0000_4004, 6'h29, 1'b1, 32'h5A5A_A5A5, 1, 1, 32'h0);
        // DTACK seen in the same cycle as the last timeout count
        run_txn(1'b0, 32'h2000_0000, 6'h0D, 1'b1, 32'h0, TIMEOUT_CYC - 2, 1, 32'h8765_4321);

        // Reset while waiting for DTACK on a write
        ack_d = 0;
        hold_h = 1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 31'h0000_1234;
        bus.req_am    = 6'h09;
        bus.req_lword = 1'b1;
        bus.req_wdata = 32'h1111_2222;
        found = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            if (bus.req_ready) begin
                found = 1'b1;
                break;
            end
            @(negedge clk50);
        end
        check_val("rst_test_accept", found, 1'b1);
        @(negedge clk50);
        bus.req_valid = 1'b0;
        repeat (20) @(negedge clk50);
        check_val("pre_rst_wait", {vme_ds0_n, vme_db_oe}, 2'b01);
        sys_rst_n = 1'b0;
        #1;
        check_val("mid_rst_strobes", {vme_as_n, vme_ds0_n, vme_ds1_n, vme_db_oe}, 4'b1110);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk50);
            check_val("rst_no_rsp", {bus.rsp_valid, bus.req_ready}, 2'b00);
        end
        sys_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk50);
            check_val("post_rst_idle", {bus.rsp_valid, vme_as_n, bus.req_ready}, 3'b011);
        end
        have_prev = 1'b0;
        run_txn(1'b0, 32'h3000_0008, 6'h09, 1'b1, 32'h0, 1, 1, 32'h0F0F_1234);

        // Randomized cycles
        for (int k = 0; k < 10; k++) begin
            logic        wr, lw;
            logic [31:0] addr, wdata, sdata;
            logic [5:0]  am;
            int          d, h;
            wr    = 1'($urandom);
            lw    = 1'($urandom);
            addr  = $urandom & 32'hFFFF_FFFE;
            am    = 6'($urandom);
            wdata = $urandom;
            sdata = $urandom;
            d     = (($urandom % 8) == 0) ? 0 : int'($urandom_range(1, 30));
            h     = int'($urandom_range(1, 20));
            run_txn(wr, addr, am, lw, wdata, d, h, sdata);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
